multicycle_alu: RTL and testbench

//  Sequential execute unit that consumes the 4-bit ALU operation code from the ALU control decoder.

---
 rtl/multicycle_alu_if.sv | 25 ++
 rtl/multicycle_alu.sv | 167 ++++++++++++++++
 tb/tb_multicycle_alu.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the main control FSM and the multi-cycle
// execute unit. The control FSM uses the master view; the ALU uses the slave view.
interface multicycle_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] ALU_Result_o;
  logic                  Zero_o;
  logic                  illegal_op_o;

  modport master (
    output start_i, ALU_Operation_i, A_i, B_i,
    input  busy_o, done_o, ALU_Result_o, Zero_o, illegal_op_o
  );

  modport slave (
    input  start_i, ALU_Operation_i, A_i, B_i,
    output busy_o, done_o, ALU_Result_o, Zero_o, illegal_op_o
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multi-cycle execute unit: latches operands on start, finishes logic and
// arithmetic ops in one cycle, shifts one bit per cycle, and returns a held
// result with a one-cycle done pulse.
// Optional feature macro: MULTICYCLE_ALU_MUL_EN adds an iterative unsigned
// shift-add multiplier for op 0111; without it 0111 is reported as illegal.
module multicycle_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  multicycle_alu_if.slave  bus
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_OR  = 4'b0010,
    OP_AND = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SLL = 4'b0101,
    OP_SRL = 4'b0110,
    OP_MUL = 4'b0111
  } op_t;

  state_t                state, state_next;
  logic                  accept;
  logic                  busy, done;

  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
`ifdef MULTICYCLE_ALU_MUL_EN
  logic [DATA_WIDTH-1:0] acc_q;
`endif
  logic [SHAMT_W-1:0]    count_q, count_load;
  logic                  shamt_zero_q;
  logic [SHAMT_W-1:0]    shamt;

  logic [DATA_WIDTH-1:0] step_value;
  logic                  step_illegal;

  logic [DATA_WIDTH-1:0] result_q;
  logic                  illegal_q;

  assign shamt  = bus.B_i[SHAMT_W-1:0];
  // A request is taken whenever the unit is not busy, which includes the DONE
  // cycle so back-to-back operations lose no cycle.
  assign accept = bus.start_i && (state != EXEC);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and handshake outputs.
  // NOTE: every output gets a default first so no path through the case leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (bus.start_i) state_next = EXEC;
      EXEC: begin
        busy = 1'b1;
        if (count_q == '0) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = bus.start_i ? EXEC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Iteration count loaded on acceptance: number of EXEC cycles minus one.
  always_comb begin
    count_load = '0;
    case (bus.ALU_Operation_i)
      OP_SLL, OP_SRL: count_load = (shamt == '0) ? '0 : shamt - SHAMT_W'(1);
`ifdef MULTICYCLE_ALU_MUL_EN
      OP_MUL:         count_load = SHAMT_W'(DATA_WIDTH - 1);
`endif
      default:        count_load = '0;
    endcase
  end

  // One EXEC iteration: final value for single-cycle ops, next partial value
  // for shifts and multiply.
  always_comb begin
    step_value   = '0;
    step_illegal = 1'b0;
    case (op_q)
      OP_ADD: step_value = a_q + b_q;
      OP_SUB: step_value = a_q - b_q;
      OP_OR:  step_value = a_q | b_q;
      OP_AND: step_value = a_q & b_q;
      OP_XOR: step_value = a_q ^ b_q;
      OP_SLL: step_value = shamt_zero_q ? a_q : (a_q << 1);
      OP_SRL: step_value = shamt_zero_q ? a_q : (a_q >> 1);
`ifdef MULTICYCLE_ALU_MUL_EN
      OP_MUL: step_value = acc_q + (b_q[0] ? a_q : '0);
`endif
      default: begin
        step_value   = '0;
        step_illegal = 1'b1;
      end
    endcase
  end

  // Operand latch, iteration datapath and completion write of result/illegal flag.
  // NOTE: working registers are reset along with the result so nothing from an
  // aborted operation survives reset; there are no memories to exclude.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
`ifdef MULTICYCLE_ALU_MUL_EN
      acc_q        <= '0;
`endif
      count_q      <= '0;
      shamt_zero_q <= 1'b0;
      result_q     <= '0;
      illegal_q    <= 1'b0;
    end else if (accept) begin
      op_q         <= bus.ALU_Operation_i;
      a_q          <= bus.A_i;
      b_q          <= bus.B_i;
`ifdef MULTICYCLE_ALU_MUL_EN
      acc_q        <= '0;
`endif
      count_q      <= count_load;
      shamt_zero_q <= (shamt == '0);
    end else if (state == EXEC) begin
      count_q <= count_q - SHAMT_W'(1);
      case (op_q)
        OP_SLL, OP_SRL: a_q <= step_value;
`ifdef MULTICYCLE_ALU_MUL_EN
        OP_MUL: begin
          acc_q <= step_value;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
        end
`endif
        default: ;
      endcase
      if (count_q == '0) begin
        result_q  <= step_value;
        illegal_q <= step_illegal;
      end
    end
  end

  assign bus.busy_o       = busy;
  assign bus.done_o       = done;
  assign bus.ALU_Result_o = result_q;
  assign bus.Zero_o       = (result_q == '0);
  assign bus.illegal_op_o = illegal_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: reset, single-cycle ops, shifts,
// handshake/back-to-back behaviour, multiply or its illegal fallback, illegal op.
module tb_multicycle_alu;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  multicycle_alu_if #(.DATA_WIDTH(DW)) bus ();

  multicycle_alu #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] prev_result;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for done_o and check latency and outputs.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp_res,
                        input logic exp_ill, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.start_i         = 1'b1;
    bus.ALU_Operation_i = op;
    bus.A_i             = a;
    bus.B_i             = b;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    check({tag, "_busy"}, DW'(bus.busy_o), 32'd1);
    check({tag, "_hold"}, bus.ALU_Result_o, prev_result);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done_o) break;
    end
    check({tag, "_lat"},     DW'(lat), DW'(exp_lat));
    check({tag, "_res"},     bus.ALU_Result_o, exp_res);
    check({tag, "_illegal"}, DW'(bus.illegal_op_o), DW'(exp_ill));
    check({tag, "_zero"},    DW'(bus.Zero_o), DW'(exp_res == '0));
    check({tag, "_idle"},    DW'(bus.busy_o), 32'd0);
    prev_result = exp_res;
  endtask

  initial begin
    int lat;
    int dones;
    reset               = 1'b1;
    bus.start_i         = 1'b0;
    bus.ALU_Operation_i = 4'b0000;
    bus.A_i             = '0;
    bus.B_i             = '0;
    prev_result         = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",    DW'(bus.busy_o), 32'd0);
    check("rst_done",    DW'(bus.done_o), 32'd0);
    check("rst_result",  bus.ALU_Result_o, 32'd0);
    check("rst_zero",    DW'(bus.Zero_o), 32'd1);
    check("rst_illegal", DW'(bus.illegal_op_o), 32'd0);
    reset = 1'b0;

    // Single-cycle arithmetic and logic
    run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 1'b0, 1);
    run_op("sub",      4'b0001, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 1);
    run_op("or",       4'b0010, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1);
    run_op("and",      4'b0011, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1);
    run_op("xor",      4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1);

    // Shifts: max amount, zero amount, upper B bits ignored
    run_op("sll31",    4'b0101, 32'h1,         32'd31,        32'h8000_0000, 1'b0, 31);
    run_op("srl0",     4'b0110, 32'h8000_0000, 32'd0,         32'h8000_0000, 1'b0, 1);
    run_op("srl4",     4'b0110, 32'h8000_0000, 32'h0000_0104, 32'h0800_0000, 1'b0, 4);

    // Multiply, or illegal when the multiplier is not built
`ifdef MULTICYCLE_ALU_MUL_EN
    run_op("mul",      4'b0111, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0, 32);
`else
    run_op("mul_off",  4'b0111, 32'h0001_0001, 32'h0001_0001, 32'h0000_0000, 1'b1, 1);
`endif

    // Illegal op, then a legal op clears the flag
    run_op("illegal",  4'b1010, 32'h3,         32'h4,         32'h0000_0000, 1'b1, 1);
    run_op("add_after",4'b0000, 32'h3,         32'h4,         32'h0000_0007, 1'b0, 1);

    // Handshake: start held for 3 edges during SLL by 8, operands changed while busy
    @(negedge clk);
    bus.start_i         = 1'b1;
    bus.ALU_Operation_i = 4'b0101;
    bus.A_i             = 32'h3;
    bus.B_i             = 32'd8;
    @(posedge clk);
    @(negedge clk);
    bus.A_i = 32'h7;
    bus.B_i = 32'd2;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 2) bus.start_i = 1'b0;
      if (bus.done_o) break;
    end
    check("hold_start_lat", DW'(lat), 32'd8);
    check("hold_start_res", bus.ALU_Result_o, 32'h0000_0300);
    // Back-to-back: request presented during the DONE cycle
    bus.start_i         = 1'b1;
    bus.ALU_Operation_i = 4'b0000;
    bus.A_i             = 32'h2;
    bus.B_i             = 32'h3;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    check("b2b_busy",      DW'(bus.busy_o), 32'd1);
    check("b2b_no_done",   DW'(bus.done_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_done",      DW'(bus.done_o), 32'd1);
    check("b2b_res",       bus.ALU_Result_o, 32'h0000_0005);
    @(posedge clk);
    @(negedge clk);
    check("b2b_single",    DW'(bus.done_o), 32'd0);
    check("b2b_idle",      DW'(bus.busy_o), 32'd0);
    prev_result = 32'h5;

    // Reset in the middle of SLL by 20 (fifth EXEC cycle)
    @(negedge clk);
    bus.start_i         = 1'b1;
    bus.ALU_Operation_i = 4'b0101;
    bus.A_i             = 32'h1;
    bus.B_i             = 32'd20;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy",    DW'(bus.busy_o), 32'd0);
    check("mid_rst_done",    DW'(bus.done_o), 32'd0);
    check("mid_rst_result",  bus.ALU_Result_o, 32'd0);
    check("mid_rst_zero",    DW'(bus.Zero_o), 32'd1);
    check("mid_rst_illegal", DW'(bus.illegal_op_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    check("mid_rst_no_done", DW'(dones), 32'd0);
    check("mid_rst_held",    bus.ALU_Result_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
